// File: rtl/adder_sequencer.sv
// Nibble-serial add/subtract engine: two requesters share one 4-bit adder,
// arbitrated round-robin, with the carry chained through a register.

module adder4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] total;
  assign total  = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
  assign sum_o  = total[3:0];
  assign cout_o = total[4];
endmodule

module adder_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             sub0,
  input  logic             sub1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt,
  output logic             gnt_id,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);
  localparam int NNIB = WIDTH / 4;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  // Handshake: reqN is a level; a grant is the single cycle where gnt is high
  // while the FSM sits in IDLE. done marks the one cycle the new result is first valid.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    nib_q, nib_d;
  logic             cy_q, cy_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_id_q, done_id_d;

  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [WIDTH+3:0] shift_in;
  logic             win_id;
  logic             win_sub;

  // Operands are shifted right each RUN cycle, so the adder always sees the low nibble.
  adder4bit u_adder (
    .a_i   (a_q[3:0]),
    .b_i   (b_q[3:0]),
    .cin_i (cy_q),
    .sum_o (nib_sum),
    .cout_o(nib_cout)
  );

  assign shift_in = {nib_sum, shadow_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    shadow_d  = shadow_q;
    result_d  = result_q;
    nib_d     = nib_q;
    cy_d      = cy_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    done_id_d = done_id_q;
    gnt       = 1'b0;
    gnt_id    = 1'b0;
    win_id    = (req0 && req1) ? ~ptr_q : req1;
    win_sub   = win_id ? sub1 : sub0;
    case (state_q)
      IDLE: begin
        if (!reset && (req0 || req1)) begin
          gnt     = 1'b1;
          gnt_id  = win_id;
          a_d     = win_id ? a1 : a0;
          b_d     = (win_id ? b1 : b0) ^ {WIDTH{win_sub}};
          cy_d    = win_sub;
          nib_d   = '0;
          id_d    = win_id;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        cy_d     = nib_cout;
        shadow_d = shift_in[WIDTH+3:4];
        nib_d    = nib_q + CW'(1);
        if (nib_q == CW'(NNIB - 1)) begin
          result_d  = shift_in[WIDTH+3:4];
          carry_d   = nib_cout;
          ovf_d     = (a_q[3] == b_q[3]) && (nib_sum[3] != a_q[3]);
          done_id_d = id_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        ptr_d   = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      shadow_q  <= '0;
      result_q  <= '0;
      nib_q     <= '0;
      cy_q      <= 1'b0;
      id_q      <= 1'b0;
      ptr_q     <= 1'b1;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      shadow_q  <= shadow_d;
      result_q  <= result_d;
      nib_q     <= nib_d;
      cy_q      <= cy_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      done_id_q <= done_id_d;
    end
  end

  assign busy      = gnt || (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign done_id   = done_id_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed bench for adder_sequencer: arithmetic boundaries, round-robin
// contention, operand stability after grant and reset mid-operation.

module tb_adder_sequencer;
  localparam int W    = 16;
  localparam int NNIB = W / 4;

  logic         clk, reset;
  logic         req0, req1, sub0, sub1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt, gnt_id, busy, done, done_id;
  logic [W-1:0] result;
  logic         carry_out, overflow;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  adder_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .sub0     (sub0),
    .sub1     (sub1),
    .a0       (a0),
    .b0       (b0),
    .a1       (a1),
    .b1       (b1),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_gnt"}, {31'd0, gnt}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_done_id"}, {31'd0, done_id}, 32'd0);
    check_eq({tag, "_result"}, {16'd0, result}, 32'd0);
    check_eq({tag, "_carry"}, {31'd0, carry_out}, 32'd0);
    check_eq({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    check_eq({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
  endtask

  // One request from requester id; served operands are scrambled every
  // cycle after the grant, so the result must come from the latched values.
  task automatic do_op(input string tag, input logic id, input logic sub,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_r, input logic exp_c, input logic exp_v);
    int lat;
    lat = 99;
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; sub1 = sub; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; sub0 = sub; a0 = a; b0 = b; end
    @(negedge clk);
    check_eq({tag, "_gnt"}, {31'd0, gnt}, 32'd1);
    check_eq({tag, "_gnt_id"}, {31'd0, gnt_id}, {31'd0, id});
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      check_eq({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
      if (id) begin a1 = W'($urandom); b1 = W'($urandom); sub1 = 1'($urandom); end
      else    begin a0 = W'($urandom); b0 = W'($urandom); sub0 = 1'($urandom); end
    end
    check_eq({tag, "_latency"}, lat, NNIB + 1);
    check_eq({tag, "_result"}, {16'd0, result}, {16'd0, exp_r});
    check_eq({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
    check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_v});
    check_eq({tag, "_done_id"}, {31'd0, done_id}, {31'd0, id});
  endtask

  // Expected queue for contention: the ids the arbiter must grant, in order.
  logic [0:0] exp_q[$];

  task automatic contention();
    int cyc, ngnt, ndone;
    int last_gnt_cyc;
    logic last_id;
    logic [0:0] exp_id;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    cyc = 0; ngnt = 0; ndone = 0; last_gnt_cyc = 0; last_id = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; sub0 = 1'b0; a0 = 16'h0101; b0 = 16'h0202;
    req1 = 1'b1; sub1 = 1'b1; a1 = 16'h0900; b1 = 16'h0100;
    @(negedge clk);
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (ngnt == 4) begin req0 = 1'b0; req1 = 1'b0; end
        @(negedge clk);
      end
      cyc++;
      if (gnt) begin
        exp_id = exp_q.pop_front();
        check_eq("rr_gnt_id", {31'd0, gnt_id}, {31'd0, exp_id});
        if (ngnt > 0) check_eq("rr_spacing", cyc - last_gnt_cyc, NNIB + 2);
        last_gnt_cyc = cyc;
        last_id = gnt_id;
        ngnt++;
      end
      if (done) begin
        check_eq("rr_done_id", {31'd0, done_id}, {31'd0, last_id});
        check_eq("rr_result", {16'd0, result}, last_id ? 32'h0800 : 32'h0303);
        ndone++;
      end
    end
    check_eq("rr_grants", ngnt, 4);
    check_eq("rr_dones", ndone, 4);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    req0 = 1'b1;
    #1 check_eq("reset_gnt_masked", {31'd0, gnt}, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    do_op("add_basic", 1'b0, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);
    do_op("add_wrap",  1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf",   1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    do_op("sub_neg",   1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",   1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    do_op("add_id1",   1'b1, 1'b0, 16'hA5A5, 16'h5A5B, 16'h0000, 1'b1, 1'b0);

    contention();

    // Reset during the second RUN cycle of a requester-1 operation.
    @(posedge clk); #1;
    req1 = 1'b1; sub1 = 1'b0; a1 = 16'h1111; b1 = 16'h2222;
    @(negedge clk);
    check_eq("abort_gnt", {31'd0, gnt}, 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_after_done", {31'd0, done}, 32'd0);
    do_op("post_reset", 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Nibble-serial add/subtract engine that time-shares a single `adder4bit` instance between two requesters. Each requester presents WIDTH-bit operands and an add/sub select. The block arbitrates round-robin, feeds the operands through the 4-bit adder one nibble per cycle, and chains the carry in a register. It returns the result with carry and signed-overflow flags.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of 4 and at least 4. `NNIB = WIDTH/4` is the nibble count.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  request level from requester 0 / 1.
- `sub0`, `sub1`  in  1  0 = A+B, 1 = A−B for the respective requester.
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands per requester.
- `gnt`  out  1  single-cycle pulse when a request is accepted.
- `gnt_id`  out  1  index of the accepted requester; valid with `gnt`.
- `busy`  out  1  high from the grant cycle through the done cycle inclusive.
- `done`  out  1  single-cycle pulse; result valid.
- `done_id`  out  1  index of the served requester; valid with `done`, held until the next grant.
- `result`  out  WIDTH  sum or difference; held until the next `done`.
- `carry_out`  out  1  final carry. For subtraction, 1 means no borrow.
- `overflow`  out  1  two's-complement overflow of the operation.

## Operation
- Exactly one `adder4bit` is instantiated. No other adder may be used for the datapath.
- Reset values: state IDLE; `gnt`, `gnt_id`, `busy`, `done`, `done_id`, `result`, `carry_out`, `overflow` all 0. The round-robin pointer is set so requester 0 wins the first contention.
- FSM states: IDLE, RUN, DONE.
- **IDLE**, no request: remain in IDLE.
  - Exactly one `reqN` high: grant that requester.
  - Both high: grant the requester not served last.
  - On grant: pulse `gnt` and `gnt_id`; latch A, B (inverted if sub), and the sub flag into internal registers; load the carry register with the sub flag; clear the nibble counter; go to RUN.
- **RUN**: each cycle, feed nibble k of the latched A and B' into the adder, with cin = carry register.
  - Write the sum nibble into result-shadow bits [4k+3:4k]; store the adder carry; increment k.
  - When k = NNIB−1 is processed, go to DONE.
  - Request inputs and operand inputs are ignored throughout RUN.
- Overflow is computed on the last nibble: `overflow` = (A msb == B' msb) && (sum msb != A msb).
- **DONE**: copy the shadow result and flags to the outputs; pulse `done` with `done_id`; update the round-robin pointer to the served id; go to IDLE.
- The request is level-sensitive. A requester must deassert `reqN` no later than the cycle after `done`, or it is treated as a new request. A `reqN` still high in the DONE cycle is not sampled; sampling resumes in IDLE.
- Reset asserted mid-operation aborts the operation. No `done` is produced, and outputs return to their reset values immediately (asynchronous).

## Timing
- The grant is in the same cycle that IDLE samples `reqN` high (cycle t).
- RUN occupies cycles t+1 … t+NNIB; DONE is cycle t+NNIB+1.
  - Latency from request sample to `done`: NNIB+1 cycles (5 for WIDTH=16).
  - Minimum spacing between back-to-back grants: NNIB+2 cycles.
- `busy` is high in cycles t … t+NNIB+1.
- `result`, `carry_out`, and `overflow` change only in the DONE cycle. They are registered outputs, visible the cycle `done` is high.
- Operands may change freely after the grant cycle.

## Test plan
- Reset, then `req0`=1, `sub0`=0, a0=0x1234, b0=0x0FCD → `gnt`/`gnt_id`=0 at t; `done` at t+5 with result=0x2201, `carry_out`=0, `overflow`=0.
- Add boundaries:
  - 0xFFFF+0x0001 → 0x0000, carry 1, overflow 0.
  - 0x7FFF+0x0001 → 0x8000, carry 0, overflow 1.
- Subtract:
  - 0x0005−0x0007 → 0xFFFE, carry 0, overflow 0.
  - 0x8000−0x0001 → 0x7FFF, carry 1, overflow 1.
- Contention: `req0` and `req1` held high continuously → grants alternate 0, 1, 0, 1. `done_id` matches `gnt_id`, and each grant is NNIB+2 = 6 cycles apart.
- Operand stability: change a0/b0 to random values every cycle after the grant → result equals the sum of the values latched at the grant.
- Reset mid-operation: assert `reset` during the 2nd RUN cycle → all outputs 0 immediately; no `done` pulse. After release, a new `req1` is served correctly with 5-cycle latency.
